// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage. It owns HI/LO and raises
// the ALU stall for the whole multi-cycle operation.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hold,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_stall,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             b_zero_q;

  logic             last_c;
  logic             mt_ok_c;
  logic             is_signed_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic [AW-1:0]    acc_next_c, prod_c;
  logic [WIDTH-1:0] quot_c, rem_c, res_hi_c, res_lo_c;

  assign last_c  = (cnt_q == CW'(WIDTH - 1));
  assign mt_ok_c = ((state_q == S_IDLE) && !start) || (state_q == S_DONE);

  // Incoming operand magnitudes; op[0]=0 selects the signed variants
  assign is_signed_c = ~op[0];
  assign a_mag_c     = (is_signed_c && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag_c     = (is_signed_c && src_b[WIDTH-1]) ? -src_b : src_b;

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift_c = acc_q[AW-1:WIDTH-1];
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    acc_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (div_diff_c[WIDTH]) acc_next_c = {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                   acc_next_c = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and final HI/LO selection
  always_comb begin
    prod_c   = neg_q ? -acc_next_c : acc_next_c;
    quot_c   = acc_next_c[WIDTH-1:0];
    rem_c    = acc_next_c[AW-1:WIDTH];
    res_hi_c = prod_c[AW-1:WIDTH];
    res_lo_c = prod_c[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_zero_q) begin
        res_hi_c = a_raw_q;
        res_lo_c = '1;
      end else begin
        res_hi_c = rem_neg_q ? -rem_c : rem_c;
        res_lo_c = neg_q ? -quot_c : quot_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)  state_d = S_BUSY;
      S_BUSY:  if (last_c) state_d = S_DONE;
      S_DONE:  if (!hold)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is combinational from start in IDLE so it lands in the issue cycle
  always_comb begin
    alu_stall = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  alu_stall = start & rst_n;
      S_BUSY:  alu_stall = 1'b1;
      default: alu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      op_q      <= op;
      opnd_q    <= op[1] ? b_mag_c : a_mag_c;
      acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag_c : b_mag_c)};
      a_raw_q   <= src_a;
      cnt_q     <= '0;
      neg_q     <= is_signed_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      rem_neg_q <= is_signed_c & src_a[WIDTH-1];
      b_zero_q  <= (src_b == '0);
    end else if (state_q == S_BUSY) begin
      acc_q <= acc_next_c;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == S_BUSY && last_c) begin
      hi <= res_hi_c;
      lo <= res_lo_c;
    end else if (mt_ok_c) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
